seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//  Iterative shift-add multiplier for the picoMIPS datapath. Sits directly
//  downstream of the operand multiplexer (register vs immediate select) and
//  consumes its output as operand b. One product bit per clock, so it uses
//  no dedicated multiplier block. Start/busy/done handshake with the
//  controller, which stalls the PC while busy.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  n_reset    in   1          asynchronous active-low reset
//  start      in   1          request: sample a, b, signed_op this edge
//  signed_op  in   1          1 = two's-complement operands, 0 = unsigned
//  a          in   WIDTH      operand a (register file port)
//  b          in   WIDTH      operand b (from operand multiplexer)
//  busy       out  1          high while a multiply is in progress
//  done       out  1          one-cycle pulse: result valid and updated
//  result     out  2*WIDTH    full product, held until next done
//  result_hi  out  WIDTH      result[2*WIDTH-1:WIDTH] (fractional scaling)
// BEHAVIOUR
//  Reset (n_reset=0, async): state=IDLE, busy=0, done=0, result=0,
//   counter=0, internal accumulator/operand registers=0. Takes effect
//   mid-operation; the in-flight multiply is discarded, no done pulse.
//  FSM states: IDLE, RUN, FINISH.
//   IDLE:   start=1 -> latch |a|, |b| (magnitudes if signed_op, else raw),
//           latch sign = signed_op & (a[MSB]^b[MSB]), acc=0,
//           counter=WIDTH, -> RUN. start=0 -> stay.
//   RUN:    busy=1. Each cycle: if multiplier LSB=1 acc += multiplicand
//           (shifted); shift multiplier right; counter--. counter reaches 0
//           -> FINISH. start ignored (no re-latch, no error).
//   FINISH: result <= sign ? -acc : acc (2*WIDTH wrap); done=1 this cycle;
//           busy=0. start=1 here is accepted exactly as in IDLE (-> RUN);
//           else -> IDLE.
//  Latency: start sampled on edge N -> busy high cycles N+1..N+WIDTH,
//   done high cycle N+WIDTH+1, result valid from that cycle. Throughput:
//   one multiply per WIDTH+1 cycles with back-to-back start.
//  done and busy are registered outputs, never high together.
//  Arithmetic: accumulator is 2*WIDTH bits unsigned; magnitude of the most
//   negative input (e.g. -128 for WIDTH=8) is 2^(WIDTH-1), representable in
//   WIDTH unsigned bits, so no overflow. Unsigned product always fits.
//  result only changes on the done cycle or reset; operand changes during
//   RUN have no effect.
// TESTING
//  1 Reset: n_reset low mid-RUN -> busy=0, done=0, result=0 immediately
//    (async); no done pulse after release.
//  2 Unsigned: a=0xFF, b=0xFF, signed_op=0, start 1 cycle -> busy 8 cycles,
//    done at cycle 9, result=0xFE01, result_hi=0xFE.
//  3 Signed: a=0x80, b=0x80 -> result=0x4000; a=0xFF, b=0x01 -> 0xFFFF;
//    a=0xFF, b=0xFF -> 0x0001.
//  4 Zero/identity: a=0x00, b=0x5A -> 0x0000; a=0x01, b=0xA5 unsigned
//    -> 0x00A5, signed -> 0xFFA5.
//  5 Handshake: start held high throughout with changing operands -> only
//    operands present on IDLE/FINISH edges used; done every 9 cycles; start
//    pulses during RUN ignored; result stable between done pulses.
//  6 Random: 1000 random a, b, signed_op vs reference model product,
//    checking latency exactly WIDTH+1 and done/busy never both high.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one product bit per clock with start/busy/done handshake
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     result_hi
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t               state;
  logic [2*WIDTH-1:0]   acc, mcand, acc_nxt, prod;
  logic [WIDTH-1:0]     mplr, mag_a, mag_b;
  logic                 sign;
  logic [CW-1:0]        cnt;
  always_comb begin
    mag_a   = (signed_op & a[WIDTH-1]) ? -a : a;
    mag_b   = (signed_op & b[WIDTH-1]) ? -b : b;
    acc_nxt = acc + (mplr[0] ? mcand : '0);
    prod    = sign ? -acc_nxt : acc_nxt;
  end
  assign result_hi = result[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{WIDTH{1'b0}}, mag_a};
            mplr  <= mag_b;
            sign  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state  <= FINISH;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= prod;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier against a cycle-level product model
module tb_seq_multiplier;
  localparam int W = 8;
  localparam int P = 2 * W;
  logic           clk = 1'b0;
  logic           n_reset = 1'b0;
  logic           start = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic           busy, done;
  logic [P-1:0]   result;
  logic [W-1:0]   result_hi;
  int             checks = 0, errors = 0;
  logic           en = 1'b0;
  int             rem = 0;
  logic           m_done = 1'b0;
  logic [P-1:0]   m_result = '0, pend = '0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint px = s ? longint'($signed(x)) : longint'(x);
    longint py = s ? longint'($signed(y)) : longint'(y);
    return P'(px * py);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted request occupies W busy cycles, then one done cycle carrying the product.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rem = 0;
      m_done = 1'b0;
      m_result = '0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        m_done = 1'b1;
        m_result = pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        rem = W;
        pend = ref_prod(a, b, signed_op);
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(m_result));
      chk("result_hi", 32'(result_hi), 32'(m_result[P-1:W]));
      chk("busy_done_excl", 32'(busy & done), 32'(0));
    end
  end

  task automatic run_mul(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic s, input logic [P-1:0] exp);
    int lat = 0;
    @(negedge clk);
    a = xa; b = xb; signed_op = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~xa; b = ~xb;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("literal_result", 32'(result), 32'(exp));
    chk("literal_hi", 32'(result_hi), 32'(exp[P-1:W]));
  endtask

  logic [W-1:0] va [10] = '{8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h80, 8'h7F};
  logic [W-1:0] vb [10] = '{8'hFF, 8'h80, 8'h01, 8'hFF, 8'h5A, 8'h5A, 8'hA5, 8'hA5, 8'h7F, 8'h7F};
  logic         vs [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [P-1:0] ve [10] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'h0001, 16'h0000,
                           16'h0000, 16'h00A5, 16'hFFA5, 16'hC080, 16'h3F01};

  initial begin
    int dcount;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_result", 32'(result), 32'(0));
    @(negedge clk);
    n_reset = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 10; i++) run_mul(va[i], vb[i], vs[i], ve[i]);
    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    a = 8'h33; b = 8'h44; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_done", 32'(done), 32'(0));
    chk("async_result", 32'(result), 32'(0));
    @(negedge clk);
    n_reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no_done_after_reset", 32'(dcount), 32'(0));
    run_mul(8'h0C, 8'h0D, 1'b0, 16'h009C);
    // Start held high with operands changing every cycle.
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); signed_op = 1'($urandom); start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    // Random back-to-back requests with junk start pulses while running.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); signed_op = 1'($urandom); start = 1'b1;
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); signed_op = 1'($urandom);
        start = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
